// File: rtl/nibble_responder_pkg.sv
// Shared widths, command layout and FSM encoding for the nibble-serial
// register-file responder.
package nibble_responder_pkg;

  localparam int ADDR_W     = 3;
  localparam int WORD_W     = 8;
  localparam int NIB_W      = 4;
  localparam int CMD_WR_BIT = 3;
  localparam int NUM_WORDS  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_HI = 3'd1,
    ST_WR_LO = 3'd2,
    ST_TURN  = 3'd3,
    ST_RD_HI = 3'd4,
    ST_RD_LO = 3'd5
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [NIB_W-1:0] nib);
    cmd_t c;
    c.wr   = nib[CMD_WR_BIT];
    c.addr = nib[ADDR_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/nibble_responder_if.sv
// Frame handshake between the initiator and the responder; the shared
// nibble bus itself stays a plain inout net on the top.
interface nibble_responder_if;
  logic req;
  logic ack;
  logic err;
  logic busy;

  modport master (output req, input  ack, input  err, input  busy);
  modport slave  (input  req, output ack, output err, output busy);
endinterface

// File: rtl/nibble_regfile.sv
// Eight-word storage: one synchronous write port, one combinational read
// port, asynchronously cleared to RESET_VAL.
module nibble_regfile
  import nibble_responder_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VAL = 8'h00
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [NUM_WORDS];

  // NOTE: the words must come out of reset holding RESET_VAL, so this array
  // is built from resettable flops rather than a RAM macro without reset.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nibble_responder.sv
// Nibble-serial responder: frame FSM, read shift register and tristate
// driver in front of an eight-word register file.
module nibble_responder
  import nibble_responder_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VAL = 8'h00
) (
  input  logic               clock,
  input  logic               clear,
  inout  wire  [NIB_W-1:0]   bus,
  nibble_responder_if.slave  ifc
);

  state_t            state, state_nxt;
  logic              oe, oe_nxt;
  logic              ack, ack_nxt;
  logic              err, err_nxt;
  logic              cmd_load, hi_load, snap_load, shift_en, we;
  logic [ADDR_W-1:0] addr_q;
  logic [NIB_W-1:0]  hi_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] rdata;
  cmd_t              cmd;

  assign cmd = decode_cmd(bus);

  nibble_regfile #(.RESET_VAL(RESET_VAL)) u_regfile (
    .clock (clock),
    .clear (clear),
    .we    (we),
    .waddr (addr_q),
    .wdata ({hi_q, bus}),
    .raddr (cmd.addr),
    .rdata (rdata)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_nxt = state;
    oe_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    cmd_load  = 1'b0;
    hi_load   = 1'b0;
    snap_load = 1'b0;
    shift_en  = 1'b0;
    we        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ifc.req) begin
          cmd_load = 1'b1;
          if (cmd.wr) begin
            state_nxt = ST_WR_HI;
          end else begin
            state_nxt = ST_TURN;
            snap_load = 1'b1;
          end
        end
      end
      ST_WR_HI: begin
        if (ifc.req) begin
          hi_load   = 1'b1;
          state_nxt = ST_WR_LO;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_LO: begin
        state_nxt = ST_IDLE;
        if (ifc.req) begin
          we      = 1'b1;
          ack_nxt = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      ST_TURN: begin
        oe_nxt    = 1'b1;
        state_nxt = ST_RD_HI;
      end
      ST_RD_HI: begin
        oe_nxt    = 1'b1;
        ack_nxt   = 1'b1;
        shift_en  = 1'b1;
        state_nxt = ST_RD_LO;
      end
      ST_RD_LO: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
      oe    <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      oe    <= oe_nxt;
      ack   <= ack_nxt;
      err   <= err_nxt;
    end
  end

  // Datapath registers are only consumed in states that loaded them first.
  always_ff @(posedge clock) begin
    if (cmd_load)  addr_q  <= cmd.addr;
    if (hi_load)   hi_q    <= bus;
    if (snap_load) shift_q <= rdata;
    else if (shift_en) shift_q <= {shift_q[WORD_W-NIB_W-1:0], {NIB_W{1'b0}}};
  end

  assign bus      = oe ? shift_q[WORD_W-1 -: NIB_W] : {NIB_W{1'bz}};
  assign ifc.ack  = ack;
  assign ifc.err  = err;
  assign ifc.busy = (state != ST_IDLE);

endmodule
